// File: rtl/eql_req_scheduler_pkg.sv
// rtl/eql_req_scheduler_pkg.sv - shared state encoding for the eql request scheduler
package eql_sched_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    GRANT    = 3'd1,
    WAIT_ACK = 3'd2,
    COUNT    = 3'd3,
    RELEASE  = 3'd4
  } state_t;

endpackage

// File: rtl/eql_req_scheduler_if.sv
// rtl/eql_req_scheduler_if.sv - requester bank / controller signals seen by the scheduler
interface eql_req_scheduler_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) ();

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [WIDTH-1:0]      ref_value;
  logic                  ackout;
  logic                  enable_count;
  logic [NREQ-1:0]       grant;
  logic                  eql;
  logic                  cont_eql;
  logic                  busy;
  logic [NREQ-1:0]       done;
  logic                  timeout;

  modport master (
    output req, req_data, ref_value, ackout, enable_count,
    input  grant, eql, cont_eql, busy, done, timeout
  );

  modport slave (
    input  req, req_data, ref_value, ackout, enable_count,
    output grant, eql, cont_eql, busy, done, timeout
  );

endinterface

// File: rtl/eql_req_scheduler_rr_picker.sv
// rtl/eql_req_scheduler_rr_picker.sv - round-robin pick of the first request after last_ptr
module rr_picker #(
  parameter int NREQ  = 4,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_ptr,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] pos;

  // Scan from farthest to nearest so the first set bit after last_ptr wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      pos = IDX_W'((int'(last_ptr) + k) % NREQ);
      if (req[pos]) begin
        valid = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/eql_req_scheduler.sv
// rtl/eql_req_scheduler.sv - round-robin share of one handshake controller with eql compare
module eql_req_scheduler
  import eql_sched_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int HOLD_MAX = 15,
  parameter int ACK_TMO  = 31
) (
  input logic            clock,
  input logic            reset,
  eql_req_scheduler_if.slave bus
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int HC_W  = $clog2(HOLD_MAX + 1);
  localparam int WC_W  = $clog2(ACK_TMO + 1);

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, last_ptr, pick_idx;
  logic              pick_valid;
  logic [HC_W-1:0]   hold_cnt;
  logic [WC_W-1:0]   wait_cnt;
  logic              cur_req, match, hold_hit, leaving;
  logic [NREQ-1:0]   grant_q, grant_d, done_q, done_d;
  logic              eql_q, eql_d, cont_q, cont_d, tmo_q, tmo_d;

  rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_picker (
    .req      (bus.req),
    .last_ptr (last_ptr),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  assign cur_req  = bus.req[idx];
  assign match    = (bus.req_data[int'(idx)*WIDTH +: WIDTH] == bus.ref_value);
  assign hold_hit = bus.enable_count && (hold_cnt == HC_W'(HOLD_MAX - 1));
  assign leaving  = (state_nxt == RELEASE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (pick_valid) state_nxt = GRANT;
      GRANT:    state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        if (!cur_req)                                state_nxt = RELEASE;
        else if (bus.ackout)                         state_nxt = COUNT;
        else if (wait_cnt == WC_W'(ACK_TMO - 1))     state_nxt = RELEASE;
      end
      COUNT:    if (!cur_req || hold_hit) state_nxt = RELEASE;
      RELEASE:  state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; a withdrawn request never pulses done or timeout.
  always_comb begin
    grant_d = '0;
    eql_d   = 1'b0;
    cont_d  = 1'b0;
    done_d  = '0;
    tmo_d   = 1'b0;
    unique case (state)
      IDLE:  if (pick_valid) grant_d = NREQ'(1) << pick_idx;
      GRANT: begin
        grant_d = grant_q;
        eql_d   = match;
      end
      WAIT_ACK: begin
        if (!leaving) begin
          grant_d = grant_q;
          eql_d   = match;
        end else begin
          tmo_d = cur_req;
        end
      end
      COUNT: begin
        if (!leaving) begin
          grant_d = grant_q;
          eql_d   = match;
          cont_d  = eql_q && match;
        end else if (cur_req) begin
          done_d = grant_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      last_ptr <= IDX_W'(NREQ - 1);
      hold_cnt <= '0;
      wait_cnt <= '0;
      grant_q  <= '0;
      eql_q    <= 1'b0;
      cont_q   <= 1'b0;
      done_q   <= '0;
      tmo_q    <= 1'b0;
    end else begin
      grant_q <= grant_d;
      eql_q   <= eql_d;
      cont_q  <= cont_d;
      done_q  <= done_d;
      tmo_q   <= tmo_d;
      unique case (state)
        IDLE:     if (pick_valid) idx <= pick_idx;
        GRANT:    wait_cnt <= '0;
        WAIT_ACK: begin
          if (wait_cnt != WC_W'(ACK_TMO)) wait_cnt <= wait_cnt + 1'b1;
          if (state_nxt == COUNT)         hold_cnt <= '0;
        end
        COUNT:    if (bus.enable_count && hold_cnt != HC_W'(HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
        RELEASE:  last_ptr <= idx;
        default: ;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.eql      = eql_q;
  assign bus.cont_eql = cont_q;
  assign bus.done     = done_q;
  assign bus.timeout  = tmo_q;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_eql_req_scheduler.sv
// tb/tb_eql_req_scheduler.sv - directed self-checking bench for eql_req_scheduler
module tb_eql_req_scheduler;

  localparam int NREQ = 4, WIDTH = 8, HOLD_MAX = 15, ACK_TMO = 31;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  eql_req_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  eql_req_scheduler #(
    .NREQ(NREQ), .WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX), .ACK_TMO(ACK_TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset;
    reset = 1'b1;
    bus.req = '0;
    bus.ackout = 1'b0;
    bus.enable_count = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wait_grant(input bit nonzero, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if ((bus.grant != '0) == nonzero) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    logic [3:0] exp_g;
    bit ok0, ok1;
    bus.req_data = '0;
    bus.ref_value = '0;
    apply_reset;
    total_cnt++; if (bus.grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", bus.grant); else pass_cnt++;
    total_cnt++; if ({bus.eql, bus.cont_eql, bus.busy, bus.timeout} !== 4'b0000) $display("FAIL rst_flags: got %b want 0000", {bus.eql, bus.cont_eql, bus.busy, bus.timeout}); else pass_cnt++;
    total_cnt++; if (bus.done !== 4'b0000) $display("FAIL rst_done: got %b want 0000", bus.done); else pass_cnt++;
    bus.req = 4'b1111;
    bus.ackout = 1'b1;
    bus.enable_count = 1'b1;
    tick;
    total_cnt++; if (bus.grant !== 4'b0001) $display("FAIL rr_first: got %b want 0001", bus.grant); else pass_cnt++;
    exp_g = 4'b0001;
    for (int n = 1; n < 4; n++) begin
      exp_g = exp_g << 1;
      wait_grant(1'b0, ok0);
      wait_grant(1'b1, ok1);
      total_cnt++;
      if (!ok0 || !ok1 || bus.grant !== exp_g)
        $display("FAIL rr_next%0d: got %b (release_seen=%0d grant_seen=%0d) want %b", n, bus.grant, ok0, ok1, exp_g);
      else pass_cnt++;
    end
  endtask

  task automatic test_match_done;
    bit seen_early;
    apply_reset;
    bus.ref_value = 8'h5A;
    bus.req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    bus.req = 4'b0100;
    bus.enable_count = 1'b1;
    tick;
    total_cnt++; if (bus.grant !== 4'b0100 || bus.eql !== 1'b0) $display("FAIL m_grant: got grant=%b eql=%b want 0100/0", bus.grant, bus.eql); else pass_cnt++;
    tick;
    total_cnt++; if (bus.eql !== 1'b1) $display("FAIL m_eql_latency: got %b want 1", bus.eql); else pass_cnt++;
    bus.ackout = 1'b1;
    tick;
    bus.ackout = 1'b0;
    tick;
    total_cnt++; if (bus.cont_eql !== 1'b1) $display("FAIL m_cont_eql: got %b want 1", bus.cont_eql); else pass_cnt++;
    seen_early = 1'b0;
    for (int k = 1; k < 14; k++) begin
      tick;
      if (bus.done !== 4'b0000 || bus.grant !== 4'b0100) seen_early = 1'b1;
    end
    total_cnt++; if (seen_early) $display("FAIL m_hold: got early release/done want grant held 15 cycles"); else pass_cnt++;
    tick;
    total_cnt++; if (bus.done !== 4'b0100 || bus.grant !== 4'b0000) $display("FAIL m_done: got done=%b grant=%b want 0100/0000", bus.done, bus.grant); else pass_cnt++;
    total_cnt++; if ({bus.eql, bus.cont_eql, bus.busy, bus.timeout} !== 4'b0010) $display("FAIL m_release_flags: got %b want 0010", {bus.eql, bus.cont_eql, bus.busy, bus.timeout}); else pass_cnt++;
    tick;
    total_cnt++; if (bus.done !== 4'b0000 || bus.busy !== 1'b0) $display("FAIL m_done_pulse: got done=%b busy=%b want 0000/0", bus.done, bus.busy); else pass_cnt++;
  endtask

  task automatic test_timeout;
    bit seen_early;
    apply_reset;
    bus.req = 4'b0010;
    tick;
    tick;
    seen_early = 1'b0;
    for (int k = 0; k < 30; k++) begin
      tick;
      if (bus.timeout !== 1'b0 || bus.grant !== 4'b0010) seen_early = 1'b1;
    end
    total_cnt++; if (seen_early) $display("FAIL to_early: got timeout/release before 31 cycles want none"); else pass_cnt++;
    tick;
    total_cnt++; if (bus.timeout !== 1'b1 || bus.grant !== 4'b0000 || bus.done !== 4'b0000) $display("FAIL to_pulse: got to=%b grant=%b done=%b want 1/0000/0000", bus.timeout, bus.grant, bus.done); else pass_cnt++;
    tick;
    total_cnt++; if (bus.timeout !== 1'b0) $display("FAIL to_one_cycle: got %b want 0", bus.timeout); else pass_cnt++;
  endtask

  task automatic test_withdraw_and_race;
    bit bad;
    apply_reset;
    bus.req = 4'b0001;
    bus.ackout = 1'b1;
    bus.enable_count = 1'b1;
    repeat (6) tick;
    bus.req = 4'b0000;
    tick;
    total_cnt++; if (bus.grant !== 4'b0000 || bus.done !== 4'b0000 || bus.busy !== 1'b1) $display("FAIL wd_release: got grant=%b done=%b busy=%b want 0000/0000/1", bus.grant, bus.done, bus.busy); else pass_cnt++;
    apply_reset;
    bus.req = 4'b0010;
    tick;
    tick;
    repeat (30) tick;
    bus.ackout = 1'b1;
    tick;
    total_cnt++; if (bus.timeout !== 1'b0 || bus.grant !== 4'b0010) $display("FAIL race_ack_wins: got to=%b grant=%b want 0/0010", bus.timeout, bus.grant); else pass_cnt++;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (bus.timeout !== 1'b0 || bus.grant !== 4'b0010) bad = 1'b1;
    end
    total_cnt++; if (bad) $display("FAIL race_in_count: got late timeout or lost grant want held in COUNT"); else pass_cnt++;
  endtask

  task automatic test_mismatch_enable;
    bit bad;
    apply_reset;
    bus.ref_value = 8'h01;
    bus.req_data = {8'h00, 8'h01, 8'h01, 8'h01};
    bus.req = 4'b1000;
    tick;
    tick;
    total_cnt++; if (bus.eql !== 1'b0 || bus.grant !== 4'b1000) $display("FAIL mm_eql: got eql=%b grant=%b want 0/1000", bus.eql, bus.grant); else pass_cnt++;
    bus.ackout = 1'b1;
    tick;
    bus.ackout = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 28; k++) begin
      bus.enable_count = (k % 2 == 0);
      tick;
      if (bus.done !== 4'b0000 || bus.eql !== 1'b0 || bus.cont_eql !== 1'b0) bad = 1'b1;
    end
    total_cnt++; if (bad) $display("FAIL mm_toggle_hold: got early done or eql/cont_eql set want none"); else pass_cnt++;
    bus.enable_count = 1'b1;
    tick;
    total_cnt++; if (bus.done !== 4'b1000) $display("FAIL mm_done: got %b want 1000", bus.done); else pass_cnt++;
  endtask

  task automatic test_reset_in_count;
    apply_reset;
    bus.ref_value = 8'h5A;
    bus.req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    bus.req = 4'b0010;
    tick;
    tick;
    bus.req = 4'b0000;
    tick;
    tick;
    bus.req = 4'b0100;
    bus.ackout = 1'b1;
    bus.enable_count = 1'b1;
    repeat (5) tick;
    total_cnt++; if (bus.grant !== 4'b0100 || bus.cont_eql !== 1'b1) $display("FAIL rc_in_count: got grant=%b cont=%b want 0100/1", bus.grant, bus.cont_eql); else pass_cnt++;
    reset = 1'b1;
    bus.req = 4'b1010;
    tick;
    total_cnt++; if ({bus.grant, bus.done} !== 8'h00 || {bus.eql, bus.cont_eql, bus.busy, bus.timeout} !== 4'b0000) $display("FAIL rc_outputs: got grant=%b done=%b flags=%b want zero", bus.grant, bus.done, {bus.eql, bus.cont_eql, bus.busy, bus.timeout}); else pass_cnt++;
    reset = 1'b0;
    tick;
    total_cnt++; if (bus.grant !== 4'b0010) $display("FAIL rc_last_ptr: got %b want 0010", bus.grant); else pass_cnt++;
  endtask

  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.ref_value = '0;
    bus.ackout = 1'b0;
    bus.enable_count = 1'b0;
    test_reset;
    test_match_done;
    test_timeout;
    test_withdraw_and_race;
    test_mismatch_enable;
    test_reset_in_count;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
